// File: rtl/jesd204b_link_ctrl.sv
// jesd204b_link_ctrl: JESD204B TX link sequencer.
// Drives the lanes through CGS (/K28.5/), a four-multiframe ILAS aligned to
// the LMFC, then DATA where transport-layer frames are forwarded unchanged.
// A run of SYNC_ERR consecutive low SYNC~ cycles during ILAS or DATA sends
// the link back to CGS.
module jesd204b_link_ctrl #(
    parameter int LANES    = 4,
    parameter int F        = 4,
    parameter int K        = 32,
    parameter int SYNC_ERR = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       sync_n,
    input  logic [14*8-1:0]            ilas_cfg,
    input  logic [LANES*F*8-1:0]       tx_data,
    output logic                       tx_ready,
    output logic [LANES*F*8-1:0]       lane_data,
    output logic [LANES*F-1:0]         lane_charisk,
    output logic [$clog2(K)-1:0]       lmfc_cnt,
    output logic [1:0]                 link_state
);

    localparam int LMFC_W = $clog2(K);
    localparam int ERR_W  = $clog2(SYNC_ERR + 1);
    localparam logic [15:0] LAST_N = 16'(K * F - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CGS  = 2'd1,
        ST_ILAS = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [LMFC_W-1:0]       lmfc_r;
    logic [1:0]              ilas_mf_r;
    logic [1:0]              next_mf_s;
    logic [ERR_W-1:0]        sync_err_cnt_r;
    logic [ERR_W-1:0]        next_err_s;
    logic                    mf_end_s;
    logic                    resync_s;
    logic [8:0]              oct_s;
    logic [LANES*F*8-1:0]    lane_data_nxt_s;
    logic [LANES*F-1:0]      charisk_nxt_s;
    logic [LANES*F*8-1:0]    lane_data_r;
    logic [LANES*F-1:0]      lane_charisk_r;

    // ILAS octet n of multiframe mf, returned as {charisk, octet}.
    function automatic logic [8:0] ilas_octet(input logic [1:0] mf,
                                              input logic [15:0] n,
                                              input logic [14*8-1:0] cfg);
        logic [8:0] r;
        logic [3:0] idx;
        idx = 4'd0;
        if (n == 16'd0) begin
            r = {1'b1, 8'h1C};
        end else if (n == LAST_N) begin
            r = {1'b1, 8'h7C};
        end else if ((mf == 2'd1) && (n == 16'd1)) begin
            r = {1'b1, 8'h9C};
        end else if ((mf == 2'd1) && (n >= 16'd2) && (n <= 16'd15)) begin
            idx = n[3:0] - 4'd2;
            r   = {1'b0, cfg[{idx, 3'b000} +: 8]};
        end else begin
            r = {1'b0, n[7:0]};
        end
        return r;
    endfunction

    assign mf_end_s = (lmfc_r == LMFC_W'(K - 1));
    assign resync_s = ((state_r == ST_ILAS) || (state_r == ST_DATA)) && !sync_n &&
                      (sync_err_cnt_r == ERR_W'(SYNC_ERR - 1));

    // Next-state, ILAS multiframe index and SYNC~ error run length.
    always_comb begin
        next_state_s = state_r;
        next_mf_s    = 2'd0;
        next_err_s   = '0;
        if (!en) begin
            next_state_s = ST_IDLE;
        end else if (resync_s) begin
            next_state_s = ST_CGS;
        end else begin
            if (((state_r == ST_ILAS) || (state_r == ST_DATA)) && !sync_n) begin
                next_err_s = sync_err_cnt_r + ERR_W'(1);
            end else begin
                next_err_s = '0;
            end
            case (state_r)
                ST_IDLE: next_state_s = ST_CGS;
                ST_CGS: begin
                    if (sync_n && mf_end_s) begin
                        next_state_s = ST_ILAS;
                    end else begin
                        next_state_s = ST_CGS;
                    end
                end
                ST_ILAS: begin
                    if (mf_end_s) begin
                        next_mf_s = ilas_mf_r + 2'd1;
                        if (ilas_mf_r == 2'd3) begin
                            next_state_s = ST_DATA;
                        end else begin
                            next_state_s = ST_ILAS;
                        end
                    end else begin
                        next_mf_s    = ilas_mf_r;
                        next_state_s = ST_ILAS;
                    end
                end
                ST_DATA: next_state_s = ST_DATA;
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // Octets and K flags the lanes will carry next cycle.
    always_comb begin
        lane_data_nxt_s = '0;
        charisk_nxt_s   = '0;
        oct_s           = 9'd0;
        case (state_r)
            ST_IDLE: begin
                lane_data_nxt_s = '0;
                charisk_nxt_s   = '0;
            end
            ST_CGS: begin
                for (int b = 0; b < LANES * F; b++) begin
                    lane_data_nxt_s[b*8 +: 8] = 8'hBC;
                    charisk_nxt_s[b]          = 1'b1;
                end
            end
            ST_ILAS: begin
                for (int i = 0; i < F; i++) begin
                    oct_s = ilas_octet(ilas_mf_r, 16'(lmfc_r) * 16'(F) + 16'(i), ilas_cfg);
                    for (int l = 0; l < LANES; l++) begin
                        lane_data_nxt_s[(l*F+i)*8 +: 8] = oct_s[7:0];
                        charisk_nxt_s[l*F+i]            = oct_s[8];
                    end
                end
            end
            ST_DATA: begin
                lane_data_nxt_s = tx_data;
                charisk_nxt_s   = '0;
            end
            default: begin
                lane_data_nxt_s = '0;
                charisk_nxt_s   = '0;
            end
        endcase
    end

    // State, LMFC counter, counters and registered lane outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            lmfc_r         <= '0;
            ilas_mf_r      <= 2'd0;
            sync_err_cnt_r <= '0;
            lane_data_r    <= '0;
            lane_charisk_r <= '0;
        end else begin
            state_r        <= next_state_s;
            lmfc_r         <= mf_end_s ? '0 : lmfc_r + LMFC_W'(1);
            ilas_mf_r      <= next_mf_s;
            sync_err_cnt_r <= next_err_s;
            lane_data_r    <= lane_data_nxt_s;
            lane_charisk_r <= charisk_nxt_s;
        end
    end

    assign tx_ready     = (state_r == ST_DATA);
    assign lane_data    = lane_data_r;
    assign lane_charisk = lane_charisk_r;
    assign lmfc_cnt     = lmfc_r;
    assign link_state   = state_r;

endmodule

// File: tb/tb_jesd204b_link_ctrl.sv
// Directed bench for jesd204b_link_ctrl: CGS, ILAS content, DATA forwarding,
// SYNC~ error tolerance, resync, enable drop and reset mid-ILAS.
module tb_jesd204b_link_ctrl;

    logic         clk = 1'b0;
    logic         rst, en, sync_n;
    logic [111:0] ilas_cfg;
    logic [127:0] tx_data;
    logic         tx_ready;
    logic [127:0] lane_data;
    logic [15:0]  lane_charisk;
    logic [4:0]   lmfc_cnt;
    logic [1:0]   link_state;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] BC_ALL = {16{8'hBC}};
    localparam logic [127:0] D0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] D1 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] D2 = 128'h61B62B63_B64B65B6_6B67B000_11223344;
    localparam logic [127:0] D3 = 128'hDEADBEEF_CAFEF00D_00000001_80000000;

    typedef struct {
        logic         en;
        logic         sync_n;
        logic [127:0] td;
        logic [1:0]   st;
        logic         rdy;
        logic [127:0] dat;
        logic [15:0]  k;
    } vec_t;

    vec_t tbl[17];

    jesd204b_link_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .sync_n(sync_n), .ilas_cfg(ilas_cfg),
        .tx_data(tx_data), .tx_ready(tx_ready), .lane_data(lane_data),
        .lane_charisk(lane_charisk), .lmfc_cnt(lmfc_cnt), .link_state(link_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
        int cnt = 0;
        while ((link_state !== s) && (cnt < budget)) begin
            tick();
            cnt++;
        end
        chk(nm, {126'd0, link_state}, {126'd0, s});
    endtask

    // Expected per-lane ILAS frame {charisk[3:0], octets[31:0]} with ilas_cfg = 01..0E.
    function automatic logic [35:0] ilas_exp(input int mf, input int fr);
        logic [31:0] d;
        logic [3:0]  k;
        int n;
        d = 32'd0;
        k = 4'd0;
        for (int i = 0; i < 4; i++) begin
            n = fr * 4 + i;
            if (n == 0) begin
                d[i*8 +: 8] = 8'h1C; k[i] = 1'b1;
            end else if (n == 127) begin
                d[i*8 +: 8] = 8'h7C; k[i] = 1'b1;
            end else if (mf == 1 && n == 1) begin
                d[i*8 +: 8] = 8'h9C; k[i] = 1'b1;
            end else if (mf == 1 && n >= 2 && n <= 15) begin
                d[i*8 +: 8] = 8'(n - 1);
            end else begin
                d[i*8 +: 8] = 8'(n);
            end
        end
        return {k, d};
    endfunction

    initial begin
        logic [35:0] e;
        // DATA phase, SYNC~ tolerance, resync, enable drop and re-enable.
        tbl[0]  = '{1'b1, 1'b1, D0, 2'd3, 1'b1, D0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b1, D1, 2'd3, 1'b1, D1, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, D2, 2'd3, 1'b1, D2, 16'h0000};
        tbl[3]  = '{1'b1, 1'b0, D3, 2'd3, 1'b1, D3, 16'h0000};
        tbl[4]  = '{1'b1, 1'b0, D0, 2'd3, 1'b1, D0, 16'h0000};
        tbl[5]  = '{1'b1, 1'b0, D1, 2'd3, 1'b1, D1, 16'h0000};
        tbl[6]  = '{1'b1, 1'b1, D2, 2'd3, 1'b1, D2, 16'h0000};
        tbl[7]  = '{1'b1, 1'b0, D3, 2'd3, 1'b1, D3, 16'h0000};
        tbl[8]  = '{1'b1, 1'b0, D0, 2'd3, 1'b1, D0, 16'h0000};
        tbl[9]  = '{1'b1, 1'b0, D1, 2'd3, 1'b1, D1, 16'h0000};
        tbl[10] = '{1'b1, 1'b0, D2, 2'd3, 1'b1, D2, 16'h0000};
        tbl[11] = '{1'b1, 1'b0, D3, 2'd1, 1'b0, D3, 16'h0000};
        tbl[12] = '{1'b1, 1'b0, D0, 2'd1, 1'b0, BC_ALL, 16'hFFFF};
        tbl[13] = '{1'b0, 1'b0, D1, 2'd0, 1'b0, BC_ALL, 16'hFFFF};
        tbl[14] = '{1'b0, 1'b0, D2, 2'd0, 1'b0, 128'd0, 16'h0000};
        tbl[15] = '{1'b1, 1'b0, D3, 2'd1, 1'b0, 128'd0, 16'h0000};
        tbl[16] = '{1'b1, 1'b0, D0, 2'd1, 1'b0, BC_ALL, 16'hFFFF};

        rst = 1'b1; en = 1'b1; sync_n = 1'b0; tx_data = 128'd0;
        for (int j = 0; j < 14; j++) ilas_cfg[j*8 +: 8] = 8'(j + 1);
        tick(); tick();
        chk("rst_state", {126'd0, link_state}, 128'd0);
        chk("rst_lmfc", {123'd0, lmfc_cnt}, 128'd0);
        chk("rst_data", lane_data, 128'd0);
        chk("rst_k", {112'd0, lane_charisk}, 128'd0);
        chk("rst_ready", {127'd0, tx_ready}, 128'd0);

        // IDLE for one cycle, then CGS.
        rst = 1'b0;
        tick();
        chk("idle_to_cgs", {126'd0, link_state}, 128'd1);
        chk("idle_out", lane_data, 128'd0);
        chk("lmfc_1", {123'd0, lmfc_cnt}, 128'd1);
        for (int c = 0; c < 40; c++) begin
            tick();
            chk("cgs_data", lane_data, BC_ALL);
            chk("cgs_k", {112'd0, lane_charisk}, {112'd0, 16'hFFFF});
            chk("cgs_ready", {127'd0, tx_ready}, 128'd0);
        end

        // SYNC~ released at lmfc 10: CGS holds until the multiframe boundary.
        begin
            int cnt = 0;
            while ((lmfc_cnt !== 5'd10) && (cnt < 64)) begin
                tick();
                cnt++;
            end
            chk("lmfc_reach_10", {123'd0, lmfc_cnt}, 128'd10);
        end
        sync_n = 1'b1;
        for (int l = 11; l < 32; l++) begin
            tick();
            chk("cgs_hold", {126'd0, link_state}, 128'd1);
            chk("cgs_lmfc", {123'd0, lmfc_cnt}, 128'(l));
        end
        tick();
        chk("ilas_entry", {126'd0, link_state}, 128'd2);
        chk("ilas_entry_lmfc", {123'd0, lmfc_cnt}, 128'd0);
        chk("cgs_last", lane_data, BC_ALL);

        // ILAS: 4 multiframes of K frames.
        tx_data = D0;
        for (int c = 0; c < 128; c++) begin
            chk("ilas_state", {126'd0, link_state}, 128'd2);
            chk("ilas_ready", {127'd0, tx_ready}, 128'd0);
            chk("ilas_lmfc", {123'd0, lmfc_cnt}, 128'(c % 32));
            tick();
            e = ilas_exp(c / 32, c % 32);
            chk("ilas_data", lane_data, {4{e[31:0]}});
            chk("ilas_k", {112'd0, lane_charisk}, {112'd0, {4{e[35:32]}}});
            if (c == 0) chk("ilas_mf0_f0", lane_data, {4{32'h0302011C}});
            if (c == 31) begin
                chk("ilas_mf0_last", lane_data, {4{32'h7C7E7D7C}});
                chk("ilas_mf0_last_k", {112'd0, lane_charisk}, {112'd0, {4{4'b1000}}});
            end
            if (c == 32) begin
                chk("ilas_mf1_f0", lane_data, {4{32'h02019C1C}});
                chk("ilas_mf1_f0_k", {112'd0, lane_charisk}, {112'd0, {4{4'b0011}}});
            end
            if (c == 33) chk("ilas_mf1_f1", lane_data, {4{32'h06050403}});
        end
        chk("data_entry", {126'd0, link_state}, 128'd3);
        chk("data_ready", {127'd0, tx_ready}, 128'd1);
        chk("data_lmfc", {123'd0, lmfc_cnt}, 128'd0);

        // Table: DATA forwarding, SYNC~ glitch tolerance, resync, enable.
        for (int v = 0; v < 17; v++) begin
            en = tbl[v].en; sync_n = tbl[v].sync_n; tx_data = tbl[v].td;
            tick();
            chk($sformatf("vec%0d_state", v), {126'd0, link_state}, {126'd0, tbl[v].st});
            chk($sformatf("vec%0d_ready", v), {127'd0, tx_ready}, {127'd0, tbl[v].rdy});
            chk($sformatf("vec%0d_data", v), lane_data, tbl[v].dat);
            chk($sformatf("vec%0d_k", v), {112'd0, lane_charisk}, {112'd0, tbl[v].k});
        end

        // Reset in the middle of ILAS, then ILAS restarts from multiframe 0.
        sync_n = 1'b1;
        wait_state(2'd2, 40, "reach_ilas");
        tick(); tick(); tick(); tick(); tick();
        chk("mid_ilas_state", {126'd0, link_state}, 128'd2);
        rst = 1'b1;
        tick();
        chk("rst_mid_state", {126'd0, link_state}, 128'd0);
        chk("rst_mid_lmfc", {123'd0, lmfc_cnt}, 128'd0);
        chk("rst_mid_data", lane_data, 128'd0);
        chk("rst_mid_k", {112'd0, lane_charisk}, 128'd0);
        chk("rst_mid_ready", {127'd0, tx_ready}, 128'd0);
        rst = 1'b0;
        tick();
        chk("restart_cgs", {126'd0, link_state}, 128'd1);
        wait_state(2'd2, 40, "reach_ilas2");
        chk("ilas2_lmfc", {123'd0, lmfc_cnt}, 128'd0);
        tick();
        chk("ilas2_mf0_f0", lane_data, {4{32'h0302011C}});
        chk("ilas2_mf0_k", {112'd0, lane_charisk}, {112'd0, {4{4'b0001}}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
